// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/decode control in, fetch address and IF/ID register out.
interface fetch_stage_if;
  logic        PCwrite;
  logic        IF_ID_en;
  logic [31:0] Instr_F;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic        nullify;
  logic [31:0] rs_fwd_D;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        valid_D;

  // Driver side: hazard unit, IM and decode stage.
  modport master (
    output PCwrite, IF_ID_en, Instr_F, npc_sel, br_taken, nullify, rs_fwd_D,
    input  PC_F, Instr_D, PC_D, PC8_D, valid_D
  );

  // Fetch stage itself.
  modport slave (
    input  PCwrite, IF_ID_en, Instr_F, npc_sel, br_taken, nullify, rs_fwd_D,
    output PC_F, Instr_D, PC_D, PC8_D, valid_D
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC mux (branches resolve in D with one
// delay slot), and the IF/ID pipeline register with stall and nullify.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_d_q;
  logic [31:0] pc_d_q;
  logic        valid_d_q;

  logic [31:0] pc_f_plus4;
  logic [31:0] br_off;

  assign pc_f_plus4 = pc_f_q + 32'd4;
  // Branch offset is taken from the instruction already in D, word-scaled.
  assign br_off     = {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};

  // Next-PC select; all arithmetic wraps mod 2^32.
  always_comb begin
    pc_f_d = pc_f_plus4;
    unique case (bus.npc_sel)
      NPC_SEQ: pc_f_d = pc_f_plus4;
      NPC_BR:  pc_f_d = bus.br_taken ? (pc_d_q + 32'd4 + br_off) : pc_f_plus4;
      NPC_J:   pc_f_d = {pc_d_q[31:28], instr_d_q[25:0], 2'b00};
      NPC_JR:  pc_f_d = bus.rs_fwd_D;
      default: pc_f_d = pc_f_plus4;
    endcase
  end

  // PC register and IF/ID register; each obeys only its own enable, and a
  // stalled IF/ID ignores nullify since the branch is not resolved yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= RESET_PC;
      instr_d_q <= 32'd0;
      pc_d_q    <= RESET_PC;
      valid_d_q <= 1'b0;
    end else begin
      if (bus.PCwrite) pc_f_q <= pc_f_d;
      if (bus.IF_ID_en) begin
        pc_d_q    <= pc_f_q;
        instr_d_q <= bus.nullify ? 32'd0 : bus.Instr_F;
        valid_d_q <= ~bus.nullify;
      end
    end
  end

  assign bus.PC_F    = pc_f_q;
  assign bus.Instr_D = instr_d_q;
  assign bus.PC_D    = pc_d_q;
  assign bus.PC8_D   = pc_d_q + 32'd8;
  assign bus.valid_D = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random traffic,
// each cycle's expected post-edge state queued and checked by a monitor.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Architectural view of the fetch stage.
  logic [31:0] m_pc, m_ir, m_pcd;
  logic        m_vld;

  function automatic logic [31:0] target(input logic [1:0] sel, input logic br,
                                         input logic [31:0] rs);
    int          off;
    logic [31:0] offb;
    off  = $signed(m_ir[15:0]);
    offb = 32'(off * 4);
    case (sel)
      2'd1:    return br ? (m_pcd + 32'd4 + offb) : (m_pc + 32'd4);
      2'd2:    return {m_pcd[31:28], m_ir[25:0], 2'b00};
      2'd3:    return rs;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, queue the expected state.
  task automatic cycle(input logic rst, input logic pcw, input logic ifen,
                       input logic [31:0] instr, input logic [1:0] sel,
                       input logic br, input logic nul, input logic [31:0] rs);
    logic [31:0] npc;
    exp_t e;
    reset        = rst;
    bus.PCwrite  = pcw;
    bus.IF_ID_en = ifen;
    bus.Instr_F  = instr;
    bus.npc_sel  = sel;
    bus.br_taken = br;
    bus.nullify  = nul;
    bus.rs_fwd_D = rs;
    if (rst) begin
      m_pc = 32'h3000; m_ir = 32'd0; m_pcd = 32'h3000; m_vld = 1'b0;
    end else begin
      npc = target(sel, br, rs);
      if (ifen) begin
        m_pcd = m_pc;
        m_ir  = nul ? 32'd0 : instr;
        m_vld = !nul;
      end
      if (pcw) m_pc = npc;
    end
    e.pc_f = m_pc; e.instr_d = m_ir; e.pc_d = m_pcd;
    e.pc8_d = m_pcd + 32'd8; e.valid_d = m_vld;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, act, req);
    end
  endtask

  // Monitor: compare registered outputs mid-cycle against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("PC_F",    bus.PC_F,    e.pc_f);
        chk("Instr_D", bus.Instr_D, e.instr_d);
        chk("PC_D",    bus.PC_D,    e.pc_d);
        chk("PC8_D",   bus.PC8_D,   e.pc8_d);
        chk("valid_D", {31'd0, bus.valid_D}, {31'd0, e.valid_d});
      end
    end
  end

  logic [31:0] r_instr, r_rs;
  logic        r_rst, r_pcw, r_ifen, r_br, r_nul;
  logic [1:0]  r_sel;

  initial begin
    reset = 1'b1;
    bus.PCwrite = 1'b0; bus.IF_ID_en = 1'b0; bus.Instr_F = 32'd0;
    bus.npc_sel = 2'd0; bus.br_taken = 1'b0; bus.nullify = 1'b0; bus.rs_fwd_D = 32'd0;
    m_pc = 32'h3000; m_ir = 32'd0; m_pcd = 32'h3000; m_vld = 1'b0;
    #1;

    // Reset, with enables and nullify asserted to show reset overrides them.
    cycle(1, 1, 1, 32'h1111_1111, 2'd3, 1'b0, 1'b1, 32'h0000_5000);
    cycle(1, 0, 0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);

    // Sequential fetch.
    cycle(0, 1, 1, 32'hA000_0000, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'hA000_0004, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'hA000_0008, 2'd0, 0, 0, 0);

    // Backward branch from PC_D=0x3004, offset -2 words -> 0x3000.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h2222_0000, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h1000_FFFE, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h3333_3333, 2'd1, 1, 0, 0);   // delay slot enters D
    cycle(0, 1, 1, 32'h4444_4444, 2'd1, 0, 0, 0);   // not-taken branch

    // Jump with index 0xC10 from PC_D 0x3010, then jr.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h0, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h0, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h0, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h0, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h0800_0C10, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h5555_5555, 2'd2, 0, 0, 0);
    cycle(0, 1, 1, 32'h6666_6666, 2'd3, 0, 0, 32'h0000_3100);

    // Stall two cycles, then resume.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h7000_0000, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h7000_0004, 2'd0, 0, 0, 0);
    cycle(0, 0, 0, 32'h7000_0008, 2'd0, 0, 0, 0);
    cycle(0, 0, 0, 32'h7000_0008, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h7000_0008, 2'd0, 0, 0, 0);

    // Nullify while stalled is ignored; nullify with load kills the slot.
    cycle(0, 0, 0, 32'h7000_000C, 2'd0, 0, 1, 0);
    cycle(0, 1, 1, 32'h7000_000C, 2'd0, 0, 1, 0);
    // Enables disagreeing in both directions.
    cycle(0, 1, 0, 32'h7000_0010, 2'd0, 0, 0, 0);
    cycle(0, 0, 1, 32'h7000_0014, 2'd0, 0, 0, 0);

    // Reset while a jr is pending, then wrap through 0xFFFFFFFC.
    cycle(1, 1, 1, 32'h0, 2'd3, 0, 0, 32'h0000_9000);
    cycle(0, 1, 1, 32'h0, 2'd3, 0, 0, 32'hFFFF_FFFC);
    cycle(0, 1, 1, 32'h0, 2'd0, 0, 0, 0);
    cycle(0, 1, 1, 32'h0, 2'd0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r_rst   = ($urandom_range(0, 39) == 0);
      r_pcw   = ($urandom_range(0, 3) != 0);
      r_ifen  = ($urandom_range(0, 3) != 0);
      r_instr = $urandom;
      r_sel   = 2'($urandom_range(0, 3));
      r_br    = 1'($urandom_range(0, 1));
      r_nul   = ($urandom_range(0, 7) == 0);
      r_rs    = $urandom & 32'hFFFF_FFFC;
      cycle(r_rst, r_pcw, r_ifen, r_instr, r_sel, r_br, r_nul, r_rs);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide reset  input  1  synchronous active-high reset, sampled on rising clk edge only.
REQ-003 SHALL provide PCwrite  input  1  PC update enable from hazard unit; 0 = stall (hold PC).
REQ-004 SHALL provide IF_ID_en  input  1  IF/ID register load enable from hazard unit; 0 = hold.
REQ-005 SHALL provide Instr_F  input  32  instruction word returned by IM for current PC_F (combinational).
REQ-006 SHALL provide npc_sel  input  2  next-PC source from D-stage control: 0 seq, 1 branch, 2 j/jal, 3 jr.
REQ-007 SHALL provide br_taken  input  1  D-stage branch comparison result, valid when npc_sel=1.
REQ-008 SHALL provide nullify  input  1  D-stage likely-branch not taken: kill delay-slot instruction in F.
REQ-009 SHALL provide rs_fwd_D  input  32  forwarded rs value, jr target.
REQ-010 SHALL provide PC_F  output  32  current fetch address to IM.
REQ-011 SHALL provide Instr_D  output  32  IF/ID instruction register, feeds hazard unit and decode.
REQ-012 SHALL provide PC_D  output  32  IF/ID PC register.
REQ-013 SHALL provide PC8_D  output  32  PC_D+8, link value for jal/bgezal.
REQ-014 SHALL provide valid_D  output  1  1 = Instr_D is a fetched (not reset/nullified) instruction.

Function
REQ-015 SHALL hold PC_F in a 32-bit register; reset value 0x00003000.
REQ-016 SHALL compute next PC: npc_sel=0 -> PC_F+4; 1 & br_taken -> PC_D+4+(signext(Instr_D[15:0])<<2); 1 & !br_taken -> PC_F+4; 2 -> {PC_D[31:28],Instr_D[25:0],2'b00}; 3 -> rs_fwd_D.
REQ-017 SHALL take immediate/index fields from Instr_D (branch resolves in D; one architectural delay slot, no flush of slot on taken branch).
REQ-018 SHALL perform all PC arithmetic mod 2^32; wrap from 0xFFFFFFFC to 0x00000000 without error.
REQ-019 SHALL load PC_F with next PC on a clk edge only when PCwrite=1; else hold.
REQ-020 SHALL, when IF_ID_en=1 and nullify=0, load Instr_D<=Instr_F, PC_D<=PC_F, valid_D<=1.
REQ-021 SHALL, when IF_ID_en=1 and nullify=1, load Instr_D<=0 (nop), PC_D<=PC_F, valid_D<=0.
REQ-022 SHALL, when IF_ID_en=0, hold Instr_D, PC_D, valid_D; nullify ignored (stall has priority, branch not yet resolved).
REQ-023 SHALL drive PC8_D = PC_D+8 combinationally from the register.
REQ-024 SHALL tolerate PCwrite/IF_ID_en disagreeing; each register obeys only its own enable.
REQ-025 SHALL have one cycle latency PC_F -> Instr_D; next-PC path purely combinational from registered state plus inputs.

Reset
REQ-026 SHALL on reset=1 at clk edge set PC_F=0x00003000, Instr_D=0, PC_D=0x00003000, valid_D=0, overriding PCwrite, IF_ID_en, nullify.
REQ-027 SHALL, reset asserted mid-stall or mid-branch, discard pending redirect; first post-reset fetch is 0x00003000.
REQ-028 SHALL keep PC8_D=0x00003008 while in reset.

Verification
REQ-029 Sequential: reset, then 3 cycles enables=1, npc_sel=0 -> PC_F 0x3000,0x3004,0x3008,0x300C; Instr_D lags by one cycle, valid_D=1.
REQ-030 Branch: PC_D=0x3004, Instr_D[15:0]=0xFFFE, npc_sel=1, br_taken=1 -> next PC_F=0x3000; delay slot at 0x3008 reaches D with valid_D=1.
REQ-031 Jump/jr: Instr_D[25:0]=0x0000C10, PC_D=0x3010, npc_sel=2 -> PC_F=0x00003040; npc_sel=3, rs_fwd_D=0x3100 -> PC_F=0x3100; PC8_D=0x3018.
REQ-032 Stall: PCwrite=IF_ID_en=0 for 2 cycles at PC_F=0x3008 -> PC_F, Instr_D, PC_D unchanged; resume advances to 0x300C.
REQ-033 Nullify vs stall: nullify=1 with IF_ID_en=0 -> Instr_D held; nullify=1 with IF_ID_en=1 -> Instr_D=0, valid_D=0, PC_D=slot PC.
REQ-034 Reset mid-branch and wrap: reset with npc_sel=3 -> PC_F=0x3000; jr to 0xFFFFFFFC then seq -> PC_F=0x00000000.
